// File: rtl/adt7320_scan_ctrl.sv
// adt7320_scan_ctrl
// Round-robin SPI scan controller for a bank of ADT7320 temperature sensors
// that share SCLK/DIN/DOUT and each have their own active-low chip-select.
// Each chip gets one register read; results land in a packed output bus.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   enable            1 = scanning permitted
//   one_shot          1 = one pass over all chips per start, 0 = continuous
//   start             one-clk pulse that begins a one-shot pass (held if early)
//   addr              sensor register address, latched at each SELECT
//   results           chip k result in bits [16k+15:16k], zero-extended
//   valid, valid_chip one-clk write strobe and the slot index written
//   busy              1 while a transaction or pause is in progress
//   cs, sclk, din     sensor pins (cs active low, sclk/din idle high)
//   dout              serial data from the sensors
//
// Optional build macro ADT7320_SCAN_ALARM_EN adds alarm_limit (signed 16-bit)
// and alarm[NCHIP-1:0]; alarm[k] is 1 when slot k's signed value is at or
// above the limit, refreshed on each write of slot k.
module adt7320_scan_ctrl #(
  parameter int NCHIP       = 3,
  parameter int CLK_DIV     = 100,
  parameter int PAUSE_TICKS = 48,
  parameter int RESP_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 one_shot,
  input  logic                 start,
  input  logic [2:0]           addr,
  output logic [16*NCHIP-1:0]  results,
  output logic                 valid,
  output logic [2:0]           valid_chip,
  output logic                 busy,
  output logic [NCHIP-1:0]     cs,
  output logic                 sclk,
  output logic                 din,
  input  logic                 dout
`ifdef ADT7320_SCAN_ALARM_EN
  ,
  input  logic signed [15:0]   alarm_limit,
  output logic [NCHIP-1:0]     alarm
`endif
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int PAUSE_W = $clog2(PAUSE_TICKS + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);
  localparam logic [2:0]         CHIP_LAST  = 3'(NCHIP - 1);
  localparam logic [4:0]         RSP_LAST   = 5'(RESP_BITS - 1);
  localparam logic [NCHIP-1:0]   CS_IDLE    = {NCHIP{1'b1}};
  localparam logic [NCHIP-1:0]   CS_ONE     = NCHIP'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_CMD_LO   = 3'd2,
    ST_CMD_HI   = 3'd3,
    ST_RSP_LO   = 3'd4,
    ST_RSP_HI   = 3'd5,
    ST_DESELECT = 3'd6,
    ST_PAUSE    = 3'd7
  } state_t;

  state_t               state_r, state_n_s;
  logic [DIV_W-1:0]     div_r;
  logic                 tick_s;
  logic [2:0]           chip_r, chip_adv_s;
  logic [4:0]           bit_r;
  logic [PAUSE_W-1:0]   pause_r;
  logic [7:0]           cmd_r;
  logic [15:0]          shift_r;
  logic                 pend_r;
  logic                 pass_done_s;
  logic [NCHIP-1:0]     cs_r, cs_n_s;
  logic                 sclk_r, sclk_n_s, din_r, din_n_s;
  logic                 busy_r, valid_r;
  logic [2:0]           valid_chip_r;
  logic [16*NCHIP-1:0]  results_r;

  assign tick_s      = (div_r == DIV_LAST);
  assign chip_adv_s  = (chip_r == CHIP_LAST) ? 3'd0 : chip_r + 3'd1;
  // A one-shot pass ends once the last slot has been written.
  assign pass_done_s = one_shot && (chip_r == CHIP_LAST);

  // Tick divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div_r <= '0;
    else if (tick_s) div_r <= '0;
    else             div_r <= div_r + DIV_W'(1);
  end

  // Next state and next pin values for the state executed on this tick.
  always_comb begin
    state_n_s = state_r;
    cs_n_s    = cs_r;
    sclk_n_s  = sclk_r;
    din_n_s   = din_r;
    case (state_r)
      ST_IDLE: begin
        cs_n_s   = CS_IDLE;
        sclk_n_s = 1'b1;
        din_n_s  = 1'b1;
        if (enable && (!one_shot || pend_r)) state_n_s = ST_SELECT;
        else                                 state_n_s = ST_IDLE;
      end
      ST_SELECT: begin
        cs_n_s    = ~(CS_ONE << chip_r);
        state_n_s = ST_CMD_LO;
      end
      ST_CMD_LO: begin
        sclk_n_s  = 1'b0;
        din_n_s   = cmd_r[7];
        state_n_s = ST_CMD_HI;
      end
      ST_CMD_HI: begin
        sclk_n_s = 1'b1;
        if (bit_r == 5'd7) state_n_s = ST_RSP_LO;
        else               state_n_s = ST_CMD_LO;
      end
      ST_RSP_LO: begin
        sclk_n_s  = 1'b0;
        din_n_s   = 1'b1;
        state_n_s = ST_RSP_HI;
      end
      ST_RSP_HI: begin
        sclk_n_s = 1'b1;
        if (bit_r == RSP_LAST) state_n_s = ST_DESELECT;
        else                   state_n_s = ST_RSP_LO;
      end
      ST_DESELECT: begin
        cs_n_s    = CS_IDLE;
        state_n_s = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (pause_r != PAUSE_LAST)          state_n_s = ST_PAUSE;
        else if (enable && !pass_done_s)    state_n_s = ST_SELECT;
        else                                state_n_s = ST_IDLE;
      end
      default: begin
        cs_n_s    = CS_IDLE;
        sclk_n_s  = 1'b1;
        din_n_s   = 1'b1;
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State register and tick-aligned pin/busy updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cs_r    <= CS_IDLE;
      sclk_r  <= 1'b1;
      din_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else if (tick_s) begin
      state_r <= state_n_s;
      cs_r    <= cs_n_s;
      sclk_r  <= sclk_n_s;
      din_r   <= din_n_s;
      busy_r  <= (state_n_s != ST_IDLE);
    end
  end

  // Start capture: only honoured while idle, consumed when the pass begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pend_r <= 1'b0;
    else if (tick_s && (state_r == ST_IDLE) && (state_n_s == ST_SELECT))
      pend_r <= 1'b0;
    else if (start && one_shot && (state_r == ST_IDLE))
      pend_r <= 1'b1;
  end

  // Shift datapath, bit/pause counters and chip index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_r   <= 8'h00;
      shift_r <= 16'h0000;
      bit_r   <= 5'd0;
      pause_r <= '0;
      chip_r  <= 3'd0;
    end else if (tick_s) begin
      case (state_r)
        ST_SELECT: begin
          cmd_r   <= {1'b0, 1'b1, addr, 3'b000};
          shift_r <= 16'h0000;
          bit_r   <= 5'd0;
        end
        ST_CMD_HI: begin
          cmd_r <= {cmd_r[6:0], 1'b0};
          bit_r <= (bit_r == 5'd7) ? 5'd0 : bit_r + 5'd1;
        end
        ST_RSP_HI: begin
          shift_r <= {shift_r[14:0], dout};
          bit_r   <= bit_r + 5'd1;
        end
        ST_DESELECT: pause_r <= '0;
        ST_PAUSE: begin
          pause_r <= pause_r + PAUSE_W'(1);
          if (pause_r == PAUSE_LAST) chip_r <= chip_adv_s;
        end
        default: ;
      endcase
    end
  end

  // Result slot write and the single-clk valid strobe at DESELECT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      results_r    <= '0;
      valid_r      <= 1'b0;
      valid_chip_r <= 3'd0;
    end else begin
      valid_r <= tick_s && (state_r == ST_DESELECT);
      if (tick_s && (state_r == ST_DESELECT)) begin
        valid_chip_r <= chip_r;
        for (int k = 0; k < NCHIP; k++)
          if (chip_r == 3'(k)) results_r[16*k +: 16] <= shift_r;
      end
    end
  end

`ifdef ADT7320_SCAN_ALARM_EN
  logic [NCHIP-1:0] alarm_r;

  // Threshold compare on the freshly written slot only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      alarm_r <= '0;
    else if (tick_s && (state_r == ST_DESELECT))
      for (int k = 0; k < NCHIP; k++)
        if (chip_r == 3'(k)) alarm_r[k] <= ($signed(shift_r) >= alarm_limit);
  end

  assign alarm = alarm_r;
`endif

  assign results    = results_r;
  assign valid      = valid_r;
  assign valid_chip = valid_chip_r;
  assign busy       = busy_r;
  assign cs         = cs_r;
  assign sclk       = sclk_r;
  assign din        = din_r;

endmodule

// File: tb/tb_adt7320_scan_ctrl.sv
// Bench for adt7320_scan_ctrl: instance A uses default parameters, instance B
// a fast 2-chip, 8-bit-response build. Each has a behavioural sensor model.
module tb_adt7320_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int low_idx(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[i] == 1'b0) return i;
    return 0;
  endfunction

  // ---------------- instance A (defaults) ----------------
  logic        a_rst_n = 1'b0, a_enable = 1'b0, a_one_shot = 1'b0, a_start = 1'b0;
  logic [2:0]  a_addr = 3'd0;
  logic [47:0] a_results;
  logic        a_valid, a_busy, a_sclk, a_din;
  logic        a_dout = 1'b1;
  logic [2:0]  a_valid_chip, a_cs;
`ifdef ADT7320_SCAN_ALARM_EN
  logic signed [15:0] a_alarm_limit = 16'sh0C81;
  logic [2:0]         a_alarm;
`endif

  adt7320_scan_ctrl u_a (
    .clk(clk), .reset_n(a_rst_n), .enable(a_enable), .one_shot(a_one_shot),
    .start(a_start), .addr(a_addr), .results(a_results), .valid(a_valid),
    .valid_chip(a_valid_chip), .busy(a_busy), .cs(a_cs), .sclk(a_sclk),
    .din(a_din), .dout(a_dout)
`ifdef ADT7320_SCAN_ALARM_EN
    , .alarm_limit(a_alarm_limit), .alarm(a_alarm)
`endif
  );

  // ---------------- instance B (2 chips, 8-bit response, fast) -----------
  logic        b_rst_n = 1'b0, b_enable = 1'b0, b_one_shot = 1'b0, b_start = 1'b0;
  logic [2:0]  b_addr = 3'd0;
  logic [31:0] b_results;
  logic        b_valid, b_busy, b_sclk, b_din;
  logic        b_dout = 1'b1;
  logic [2:0]  b_valid_chip;
  logic [1:0]  b_cs;
  logic [7:0]  b_r0 = 8'hA5, b_r1 = 8'h3C;
`ifdef ADT7320_SCAN_ALARM_EN
  logic signed [15:0] b_alarm_limit = 16'sh0000;
  logic [1:0]         b_alarm;
`endif

  adt7320_scan_ctrl #(.NCHIP(2), .CLK_DIV(4), .PAUSE_TICKS(2), .RESP_BITS(8)) u_b (
    .clk(clk), .reset_n(b_rst_n), .enable(b_enable), .one_shot(b_one_shot),
    .start(b_start), .addr(b_addr), .results(b_results), .valid(b_valid),
    .valid_chip(b_valid_chip), .busy(b_busy), .cs(b_cs), .sclk(b_sclk),
    .din(b_din), .dout(b_dout)
`ifdef ADT7320_SCAN_ALARM_EN
    , .alarm_limit(b_alarm_limit), .alarm(b_alarm)
`endif
  );

  // ---------------- sensor model A: returns 0x0C80+k ----------------
  int         a_edges = 0, a_low_start = 0;
  logic       a_sclk_q = 1'b1;
  logic [2:0] a_cs_q = 3'b111;
  logic [7:0] a_cmd_sh = 8'h00;
  logic [15:0] a_word = 16'h0000;
  logic [7:0] a_cmd_log[$];
  int         a_low_log[$];

  always @(a_cs or a_sclk) begin
    if (a_cs == 3'b111) begin
      if (a_cs_q != 3'b111) a_low_log.push_back(cyc - a_low_start);
      a_edges = 0;
    end else begin
      if (a_cs_q == 3'b111) begin
        a_low_start = cyc;
        a_word = 16'h0C80 + 16'(low_idx({5'b11111, a_cs}, 3));
      end
      if (a_sclk && !a_sclk_q) begin
        if (a_edges < 8) a_cmd_sh = {a_cmd_sh[6:0], a_din};
        a_edges++;
        if (a_edges == 8) a_cmd_log.push_back(a_cmd_sh);
      end else if (!a_sclk && a_sclk_q && a_edges >= 8 && a_edges < 24) begin
        a_dout = a_word[23 - a_edges];
      end
    end
    a_cs_q   = a_cs;
    a_sclk_q = a_sclk;
  end

  // ---------------- sensor model B: 8-bit words b_r0 / b_r1 ----------------
  int         b_edges = 0, b_low_start = 0;
  logic       b_sclk_q = 1'b1;
  logic [1:0] b_cs_q = 2'b11;
  logic [7:0] b_cmd_sh = 8'h00;
  logic [7:0] b_word = 8'h00;
  logic [7:0] b_cmd_log[$];
  int         b_low_log[$];

  always @(b_cs or b_sclk) begin
    if (b_cs == 2'b11) begin
      if (b_cs_q != 2'b11) b_low_log.push_back(cyc - b_low_start);
      b_edges = 0;
    end else begin
      if (b_cs_q == 2'b11) begin
        b_low_start = cyc;
        b_word = (b_cs[0] == 1'b0) ? b_r0 : b_r1;
      end
      if (b_sclk && !b_sclk_q) begin
        if (b_edges < 8) b_cmd_sh = {b_cmd_sh[6:0], b_din};
        b_edges++;
        if (b_edges == 8) b_cmd_log.push_back(b_cmd_sh);
      end else if (!b_sclk && b_sclk_q && b_edges >= 8 && b_edges < 16) begin
        b_dout = b_word[15 - b_edges];
      end
    end
    b_cs_q   = b_cs;
    b_sclk_q = b_sclk;
  end

  // Cycle counter and valid logging.
  int a_vtime[$];
  int a_vchip[$];
  int b_nval = 0;
  always @(posedge clk) begin
    cyc++;
    if (a_valid === 1'b1) begin
      a_vtime.push_back(cyc);
      a_vchip.push_back(int'(a_valid_chip));
    end
    if (b_valid === 1'b1) b_nval++;
  end

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [7:0]  cmd;
    logic [31:0] res;
  } vec_t;
  vec_t vecs[4];

  int exp_chip[4] = '{0, 1, 2, 0};
  logic [7:0] exp_cmd[4] = '{8'h50, 8'h50, 8'h50, 8'h68};

  initial begin
    int nv0, nc0, nl0;
    logic seen, early;

    vecs[0] = '{3'd5, 8'hA5, 8'h3C, 8'h68, 32'h003C_00A5};
    vecs[1] = '{3'd0, 8'hFF, 8'h00, 8'h40, 32'h0000_00FF};
    vecs[2] = '{3'd7, 8'h01, 8'h80, 8'h78, 32'h0080_0001};
    vecs[3] = '{3'd3, 8'h5A, 8'hC3, 8'h58, 32'h00C3_005A};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("a_rst_cs", a_cs, 3'b111);
    check("a_rst_pins", {a_sclk, a_din}, 2'b11);
    check("a_rst_results", a_results, 48'h0);
    check("a_rst_flags", {a_valid, a_busy, a_valid_chip}, 5'b0);
    check("b_rst_cs", b_cs, 2'b11);
    check("b_rst_results", b_results, 32'h0);
    a_cmd_log.delete(); a_low_log.delete();
    b_cmd_log.delete(); b_low_log.delete();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // ---- A: continuous scan, addr=2 then 5 ----
    a_addr   = 3'd2;
    a_enable = 1'b1;
    for (int n = 0; n < 40000 && a_vtime.size() < 3; n++) @(negedge clk);
    check("a_results_pass", a_results, 48'h0C82_0C81_0C80);
`ifdef ADT7320_SCAN_ALARM_EN
    check("a_alarm", a_alarm, 3'b110);
`endif
    a_addr = 3'd5;
    for (int n = 0; n < 15000 && a_vtime.size() < 4; n++) @(negedge clk);
    a_enable = 1'b0;
    check("a_valid_count", a_vtime.size(), 4);
    for (int i = 0; i < a_vtime.size() && i < 4; i++)
      check($sformatf("a_valid_chip%0d", i), a_vchip[i], exp_chip[i]);
    for (int i = 1; i < a_vtime.size(); i++)
      check($sformatf("a_valid_gap%0d", i), a_vtime[i] - a_vtime[i-1], 9800);
    check("a_cmd_count", a_cmd_log.size(), 4);
    for (int i = 0; i < a_cmd_log.size() && i < 4; i++)
      check($sformatf("a_cmd%0d", i), a_cmd_log[i], exp_cmd[i]);
    for (int i = 0; i < a_low_log.size(); i++)
      check($sformatf("a_cs_low%0d", i), a_low_log[i], 4900);

    // ---- B: one-shot table ----
    b_one_shot = 1'b1;
    b_enable   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_addr = vecs[i].addr;
      b_r0   = vecs[i].r0;
      b_r1   = vecs[i].r1;
      nv0 = b_nval; nc0 = b_cmd_log.size(); nl0 = b_low_log.size();
      @(negedge clk) b_start = 1'b1;
      @(negedge clk) b_start = 1'b0;
      for (int n = 0; n < 100 && !b_busy; n++) @(negedge clk);
      check($sformatf("b_busy_rise%0d", i), b_busy, 1'b1);
      b_start = 1'b1;
      @(negedge clk) b_start = 1'b0;
      for (int n = 0; n < 2000 && b_busy; n++) @(negedge clk);
      repeat (200) @(negedge clk);
      check($sformatf("b_valids%0d", i), b_nval - nv0, 2);
      check($sformatf("b_results%0d", i), b_results, vecs[i].res);
      check($sformatf("b_idle%0d", i), {b_busy, b_cs, b_sclk}, 4'b0111);
      check($sformatf("b_cmd_count%0d", i), b_cmd_log.size() - nc0, 2);
      for (int j = nc0; j < b_cmd_log.size(); j++)
        check($sformatf("b_cmd%0d_%0d", i, j - nc0), b_cmd_log[j], vecs[i].cmd);
      for (int j = nl0; j < b_low_log.size(); j++)
        check($sformatf("b_cs_low%0d_%0d", i, j - nl0), b_low_log[j], 132);
    end

    // ---- B: enable dropped during response bit 5 ----
    b_one_shot = 1'b0;
    b_r0 = 8'hA5;
    b_r1 = 8'h3C;
    nv0 = b_nval;
    b_enable = 1'b1;
    for (int n = 0; n < 2000 && b_edges != 13; n++) @(negedge clk);
    check("b_drop_reach", b_edges, 13);
    b_enable = 1'b0;
    for (int n = 0; n < 2000 && b_busy; n++) @(negedge clk);
    repeat (200) @(negedge clk);
    check("b_drop_valids", b_nval - nv0, 1);
    check("b_drop_chip", b_valid_chip, 3'd0);
    check("b_drop_slot", b_results[15:0], 16'h00A5);
    check("b_drop_idle", {b_busy, b_cs}, 3'b011);

    // ---- B: reset mid-command ----
    b_enable = 1'b1;
    for (int n = 0; n < 2000 && !(b_edges == 3 && b_sclk == 1'b0); n++) @(negedge clk);
    check("b_rst_reach", {b_edges[3:0], b_sclk}, 5'b00110);
    b_rst_n = 1'b0;
    #1;
    check("b_rst_pins", {b_cs, b_sclk, b_din}, 4'b1111);
    check("b_rst_clear", {b_busy, b_results}, 33'h0);
    @(negedge clk) b_rst_n = 1'b1;
    seen = 1'b0;
    early = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (b_valid) seen = 1'b1;
      else if (b_results != 32'h0) early = 1'b1;
    end
    check("b_rst_seen", seen, 1'b1);
    check("b_rst_early", early, 1'b0);
    check("b_rst_chip", b_valid_chip, 3'd0);
    check("b_rst_results", b_results, 32'h0000_00A5);
    b_enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
